esp32_ospi_bus_bridge: RTL and testbench

Parametrised back end behind the ESP32-S3 Octal SPI protocol processor. It serves the processor's register and memory request ports, and replaces the fixed 16-register / 256-byte target. It provides a configurable register file with read-only identity registers and an interrupt/doorbell block, a local byte memory in SPACE 0, and forwarding of SPACES 1..EXT_SPACES to FPGA fabric. Writes are buffered through a FIFO; reads use a timeout-protected handshake.

---
 rtl/esp32_ospi_pkg.sv | 42 ++++
 rtl/esp32_ospi_wfifo.sv | 56 +++++
 rtl/esp32_ospi_bus_bridge.sv | 197 +++++++++++++++++++
 tb/tb_esp32_ospi_bus_bridge.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_ospi_pkg.sv
// rtl/esp32_ospi_pkg.sv - shared constants, types and helpers for the OSPI bus bridge
package esp32_ospi_pkg;

  localparam logic [6:0] REG_ID0    = 7'd0;
  localparam logic [6:0] REG_ID1    = 7'd1;
  localparam logic [6:0] REG_ID2    = 7'd2;
  localparam logic [6:0] REG_ID3    = 7'd3;
  localparam logic [6:0] REG_PROTO  = 7'd4;
  localparam logic [6:0] REG_CAP    = 7'd5;
  localparam logic [6:0] REG_STATUS = 7'd6;
  localparam logic [6:0] REG_IRQ_EN = 7'd7;
  localparam logic [6:0] REG_USER0  = 7'd8;

  localparam logic [7:0] ID0       = 8'h41;
  localparam logic [7:0] ID1       = 8'h32;
  localparam logic [7:0] ID2       = 8'h46;
  localparam logic [7:0] ID3       = 8'h50;
  localparam logic [7:0] PROTO_VER = 8'h02;

  localparam int ST_DB_LSB = 0;
  localparam int ST_RD_TO  = 6;
  localparam int ST_WF_OVF = 7;

  typedef struct packed {
    logic [2:0]  space;
    logic [23:0] addr;
    logic [7:0]  data;
  } ext_wr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOCAL,
    RD_DRAIN,
    RD_REQ
  } rd_state_t;

  // Spaces 1..n_ext are forwarded to fabric; space 0 is local.
  function automatic logic space_is_ext(input logic [2:0] space, input int n_ext);
    return (space != 3'd0) && (int'(space) <= n_ext);
  endfunction

endpackage

// File: rtl/esp32_ospi_wfifo.sv
// rtl/esp32_ospi_wfifo.sv - synchronous FIFO of external write entries
module esp32_ospi_wfifo
  import esp32_ospi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ext_wr_t push_data,
  input  logic    ready,
  output logic    valid,
  output ext_wr_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  ext_wr_t       mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign valid   = !empty;
  assign head    = mem[rptr];
  assign do_pop  = valid && ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/esp32_ospi_bus_bridge.sv
// rtl/esp32_ospi_bus_bridge.sv - register file, local memory and fabric forwarding behind the OSPI processor
module esp32_ospi_bus_bridge
  import esp32_ospi_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int LOCAL_AW    = 8,
  parameter int EXT_SPACES  = 1,
  parameter int WFIFO_DEPTH = 8,
  parameter int RD_TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reg_wr_req,
  input  logic [6:0]                reg_idx,
  input  logic [7:0]                reg_wdata,
  output logic [7:0]                reg_rdata,
  input  logic                      mem_wr_en,
  input  logic [2:0]                mem_space,
  input  logic [23:0]               mem_wr_addr,
  input  logic [7:0]                mem_wr_data,
  input  logic                      mem_rd_req,
  input  logic [2:0]                mem_rd_space,
  input  logic [23:0]               mem_rd_addr,
  output logic                      mem_rd_valid,
  output logic [7:0]                mem_rd_data,
  output logic                      ext_wr_valid,
  input  logic                      ext_wr_ready,
  output logic [2:0]                ext_wr_space,
  output logic [23:0]               ext_wr_addr,
  output logic [7:0]                ext_wr_data,
  output logic                      ext_rd_req,
  output logic [2:0]                ext_rd_space,
  output logic [23:0]               ext_rd_addr,
  input  logic                      ext_rd_ack,
  input  logic [7:0]                ext_rd_data,
  input  logic [3:0]                fabric_irq_set,
  output logic [8*(NUM_REGS-8)-1:0] host_regs,
  output logic                      esp_irq
);

  localparam int NUM_USER = NUM_REGS - 8;
  localparam int TMO_W    = $clog2(RD_TIMEOUT + 1);

  logic [7:0]       status_q;
  logic [7:0]       irq_en_q;
  logic [7:0]       user_q [NUM_USER];
  logic [7:0]       lmem [2**LOCAL_AW];
  rd_state_t        rd_state;
  logic [TMO_W-1:0] tmo_cnt;

  logic    wr_is_ext;
  logic    wr_ovf;
  logic    fifo_valid;
  logic    fifo_full;
  logic    fifo_empty;
  ext_wr_t fifo_in;
  ext_wr_t fifo_head;

  logic       rd_busy;
  logic       rd_ack_evt;
  logic       rd_to_evt;
  logic [7:0] status_set;
  logic [7:0] status_clr;

  assign wr_is_ext = mem_wr_en && space_is_ext(mem_space, EXT_SPACES);
  assign fifo_in   = '{space: mem_space, addr: mem_wr_addr, data: mem_wr_data};
  assign wr_ovf    = wr_is_ext && fifo_full && !(fifo_valid && ext_wr_ready);

  esp32_ospi_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_is_ext),
    .push_data (fifo_in),
    .ready     (ext_wr_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The FIFO storage is not reset, so the head is masked to keep idle outputs at zero.
  assign ext_wr_valid = fifo_valid;
  assign ext_wr_space = fifo_valid ? fifo_head.space : 3'd0;
  assign ext_wr_addr  = fifo_valid ? fifo_head.addr  : 24'd0;
  assign ext_wr_data  = fifo_valid ? fifo_head.data  : 8'd0;

  assign rd_busy    = (rd_state == RD_DRAIN) || (rd_state == RD_REQ);
  assign rd_ack_evt = (rd_state == RD_REQ) && ext_rd_ack;
  assign rd_to_evt  = rd_busy && !rd_ack_evt && (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));

  always_comb begin
    status_set                        = 8'h00;
    status_set[ST_DB_LSB +: 4]        = fabric_irq_set;
    status_set[ST_RD_TO]              = rd_to_evt;
    status_set[ST_WF_OVF]             = wr_ovf;
    status_clr = (reg_wr_req && reg_idx == REG_STATUS) ? reg_wdata : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 8'h00;
      irq_en_q <= 8'h00;
      esp_irq  <= 1'b0;
      for (int i = 0; i < NUM_USER; i++) user_q[i] <= 8'h00;
    end else begin
      // Set is OR-ed after the clear so a coincident event survives a W1C.
      status_q <= (status_q & ~status_clr) | status_set;
      esp_irq  <= |(status_q & irq_en_q);
      if (reg_wr_req && reg_idx == REG_IRQ_EN) irq_en_q <= reg_wdata;
      for (int i = 0; i < NUM_USER; i++) begin
        if (reg_wr_req && reg_idx == REG_USER0 + 7'(i)) user_q[i] <= reg_wdata;
      end
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_idx)
      REG_ID0:    reg_rdata = ID0;
      REG_ID1:    reg_rdata = ID1;
      REG_ID2:    reg_rdata = ID2;
      REG_ID3:    reg_rdata = ID3;
      REG_PROTO:  reg_rdata = PROTO_VER;
      REG_CAP:    reg_rdata = {3'(EXT_SPACES), 5'(LOCAL_AW)};
      REG_STATUS: reg_rdata = status_q;
      REG_IRQ_EN: reg_rdata = irq_en_q;
      default: begin
        for (int i = 0; i < NUM_USER; i++) begin
          if (reg_idx == REG_USER0 + 7'(i)) reg_rdata = user_q[i];
        end
      end
    endcase
  end

  for (genvar g = 0; g < NUM_USER; g++) begin : g_host
    assign host_regs[8*g +: 8] = user_q[g];
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en && mem_space == 3'd0) lmem[mem_wr_addr[LOCAL_AW-1:0]] <= mem_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state     <= RD_IDLE;
      tmo_cnt      <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= 8'h00;
      ext_rd_req   <= 1'b0;
      ext_rd_space <= 3'd0;
      ext_rd_addr  <= 24'd0;
    end else begin
      mem_rd_valid <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (mem_rd_req) begin
            if (mem_rd_space == 3'd0) begin
              rd_state     <= RD_LOCAL;
              mem_rd_valid <= 1'b1;
              mem_rd_data  <= lmem[mem_rd_addr[LOCAL_AW-1:0]];
            end else if (space_is_ext(mem_rd_space, EXT_SPACES)) begin
              rd_state     <= RD_DRAIN;
              tmo_cnt      <= '0;
              ext_rd_space <= mem_rd_space;
              ext_rd_addr  <= mem_rd_addr;
            end else begin
              rd_state     <= RD_LOCAL;
              mem_rd_valid <= 1'b1;
              mem_rd_data  <= 8'hFF;
            end
          end
        end
        RD_LOCAL: rd_state <= RD_IDLE;
        RD_DRAIN, RD_REQ: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (rd_ack_evt) begin
            rd_state     <= RD_IDLE;
            ext_rd_req   <= 1'b0;
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= ext_rd_data;
          end else if (rd_to_evt) begin
            rd_state     <= RD_IDLE;
            ext_rd_req   <= 1'b0;
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= 8'hFF;
          end else if (rd_state == RD_DRAIN && fifo_empty) begin
            // Queued writes have all left, so the read cannot overtake them.
            rd_state   <= RD_REQ;
            ext_rd_req <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp32_ospi_bus_bridge.sv
// tb/tb_esp32_ospi_bus_bridge.sv - randomized self-checking bench for esp32_ospi_bus_bridge
module tb_esp32_ospi_bus_bridge;

  localparam int NUM_REGS    = 16;
  localparam int LOCAL_AW    = 8;
  localparam int EXT_SPACES  = 1;
  localparam int WFIFO_DEPTH = 8;
  localparam int RD_TIMEOUT  = 64;
  localparam int NUM_USER    = NUM_REGS - 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  reg_wr_req = 1'b0;
  logic [6:0]            reg_idx = '0;
  logic [7:0]            reg_wdata = '0;
  logic [7:0]            reg_rdata;
  logic                  mem_wr_en = 1'b0;
  logic [2:0]            mem_space = '0;
  logic [23:0]           mem_wr_addr = '0;
  logic [7:0]            mem_wr_data = '0;
  logic                  mem_rd_req = 1'b0;
  logic [2:0]            mem_rd_space = '0;
  logic [23:0]           mem_rd_addr = '0;
  logic                  mem_rd_valid;
  logic [7:0]            mem_rd_data;
  logic                  ext_wr_valid;
  logic                  ext_wr_ready = 1'b0;
  logic [2:0]            ext_wr_space;
  logic [23:0]           ext_wr_addr;
  logic [7:0]            ext_wr_data;
  logic                  ext_rd_req;
  logic [2:0]            ext_rd_space;
  logic [23:0]           ext_rd_addr;
  logic                  ext_rd_ack = 1'b0;
  logic [7:0]            ext_rd_data = '0;
  logic [3:0]            fabric_irq_set = '0;
  logic [8*NUM_USER-1:0] host_regs;
  logic                  esp_irq;

  esp32_ospi_bus_bridge #(
    .NUM_REGS(NUM_REGS), .LOCAL_AW(LOCAL_AW), .EXT_SPACES(EXT_SPACES),
    .WFIFO_DEPTH(WFIFO_DEPTH), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_req(reg_wr_req), .reg_idx(reg_idx), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .mem_wr_en(mem_wr_en), .mem_space(mem_space), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_req(mem_rd_req), .mem_rd_space(mem_rd_space), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .ext_wr_valid(ext_wr_valid), .ext_wr_ready(ext_wr_ready), .ext_wr_space(ext_wr_space),
    .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .ext_rd_req(ext_rd_req), .ext_rd_space(ext_rd_space), .ext_rd_addr(ext_rd_addr),
    .ext_rd_ack(ext_rd_ack), .ext_rd_data(ext_rd_data),
    .fabric_irq_set(fabric_irq_set), .host_regs(host_regs), .esp_irq(esp_irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  ref_user [NUM_USER];
  logic [7:0]  ref_mem [2**LOCAL_AW];
  logic [34:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [6:0] idx, output logic [7:0] v);
    reg_idx = idx;
    #1;
    v = reg_rdata;
  endtask

  task automatic wr_reg(input logic [6:0] idx, input logic [7:0] d);
    reg_wr_req = 1'b1; reg_idx = idx; reg_wdata = d;
    step();
    reg_wr_req = 1'b0;
  endtask

  task automatic mem_wr(input logic [2:0] sp, input logic [23:0] a, input logic [7:0] d);
    mem_wr_en = 1'b1; mem_space = sp; mem_wr_addr = a; mem_wr_data = d;
    step();
    mem_wr_en = 1'b0;
  endtask

  function automatic logic [8*NUM_USER-1:0] exp_host();
    logic [8*NUM_USER-1:0] h;
    for (int i = 0; i < NUM_USER; i++) h[8*i +: 8] = ref_user[i];
    return h;
  endfunction

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++; if ({mem_rd_valid, mem_rd_data, ext_wr_valid, ext_wr_space, ext_wr_addr, ext_wr_data,
                     ext_rd_req, ext_rd_space, ext_rd_addr, esp_irq} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs valid=%b data=%h wr_valid=%b rd_req=%b irq=%b want all 0",
                         mem_rd_valid, mem_rd_data, ext_wr_valid, ext_rd_req, esp_irq); end
    n_checks++; if (host_regs !== '0) begin n_fail++; $display("FAIL reset_host_regs: got %h want 0", host_regs); end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NUM_USER; i++) ref_user[i] = 8'h00;
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", v); end
    rd_reg(7'd7, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_irq_en: got %h want 00", v); end
  endtask

  task automatic test_id_regs();
    logic [7:0] exp_id [6];
    logic [7:0] v;
    logic [6:0] idx;
    exp_id[0] = 8'h41; exp_id[1] = 8'h32; exp_id[2] = 8'h46; exp_id[3] = 8'h50; exp_id[4] = 8'h02;
    exp_id[5] = 8'((EXT_SPACES % 8) * 32 + (LOCAL_AW % 32));
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        rd_reg(7'(i), v);
        n_checks++; if (v !== exp_id[i]) begin n_fail++; $display("FAIL id_reg%0d pass%0d: got %h want %h", i, pass, v, exp_id[i]); end
      end
      if (pass == 0) for (int i = 0; i < 6; i++) wr_reg(7'(i), (i == 0) ? 8'hFF : 8'($urandom));
    end
    for (int k = 0; k < 4; k++) begin
      idx = 7'($urandom_range(NUM_REGS, 127));
      wr_reg(idx, 8'($urandom_range(1, 255)));
      rd_reg(idx, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL oob_reg%0d: got %h want 00", idx, v); end
    end
    n_checks++; if (host_regs !== exp_host()) begin n_fail++; $display("FAIL oob_host_regs: got %h want %h", host_regs, exp_host()); end
  endtask

  task automatic test_user_regs();
    logic [7:0] v;
    int i;
    for (int k = 0; k < 24; k++) begin
      i = $urandom_range(0, NUM_USER - 1);
      ref_user[i] = 8'($urandom);
      wr_reg(7'(8 + i), ref_user[i]);
    end
    for (int j = 0; j < NUM_USER; j++) begin
      rd_reg(7'(8 + j), v);
      n_checks++; if (v !== ref_user[j]) begin n_fail++; $display("FAIL user_reg%0d: got %h want %h", 8 + j, v, ref_user[j]); end
    end
    n_checks++; if (host_regs !== exp_host()) begin n_fail++; $display("FAIL host_regs: got %h want %h", host_regs, exp_host()); end
  endtask

  task automatic test_local_mem();
    logic [23:0] addrs [$];
    logic [23:0] a;
    logic [7:0]  d;
    logic [7:0]  old;
    logic [7:0]  v;
    mem_wr(3'd0, 24'h010012, 8'hA5);
    ref_mem[8'h12] = 8'hA5;
    addrs.push_back(24'h000012);
    for (int k = 0; k < 16; k++) begin
      a = 24'($urandom); d = 8'($urandom);
      mem_wr(3'd0, a, d);
      ref_mem[a[7:0]] = d;
      addrs.push_back(a);
    end
    for (int k = 0; k < 17; k++) begin
      a = (k == 0) ? addrs[0] : addrs[$urandom_range(0, addrs.size() - 1)];
      mem_rd_req = 1'b1; mem_rd_space = 3'd0; mem_rd_addr = {8'($urandom), a[15:0]};
      step();
      mem_rd_req = 1'b0;
      n_checks++; if (mem_rd_valid !== 1'b1 || mem_rd_data !== ref_mem[a[7:0]]) begin
        n_fail++; $display("FAIL local_read %h: got valid=%b data=%h want valid=1 data=%h", a, mem_rd_valid, mem_rd_data, ref_mem[a[7:0]]); end
      step();
      n_checks++; if (mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL local_read_pulse: got valid=%b want 0", mem_rd_valid); end
    end
    a = addrs[1]; old = ref_mem[a[7:0]]; d = ~old;
    mem_wr_en = 1'b1; mem_space = 3'd0; mem_wr_addr = a; mem_wr_data = d;
    mem_rd_req = 1'b1; mem_rd_space = 3'd0; mem_rd_addr = a;
    step();
    mem_wr_en = 1'b0; mem_rd_req = 1'b0;
    ref_mem[a[7:0]] = d;
    n_checks++; if (mem_rd_data !== old) begin n_fail++; $display("FAIL same_cycle_old: got %h want %h", mem_rd_data, old); end
    step();
    mem_rd_req = 1'b1;
    step();
    mem_rd_addr = addrs[2];
    step();
    mem_rd_req = 1'b0;
    n_checks++; if (mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL busy_ignore: got valid=%b want 0", mem_rd_valid); end
    step();
    for (int s = 2; s < 8; s++) begin
      mem_rd_req = 1'b1; mem_rd_space = 3'(s); mem_rd_addr = 24'($urandom);
      step();
      mem_rd_req = 1'b0;
      n_checks++; if (mem_rd_valid !== 1'b1 || mem_rd_data !== 8'hFF) begin
        n_fail++; $display("FAIL unmapped_read%0d: got valid=%b data=%h want 1/ff", s, mem_rd_valid, mem_rd_data); end
      step();
    end
    mem_wr(3'($urandom_range(2, 7)), 24'($urandom), 8'($urandom));
    n_checks++; if (ext_wr_valid !== 1'b0) begin n_fail++; $display("FAIL unmapped_write: got ext_wr_valid=%b want 0", ext_wr_valid); end
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_write_status: got %h want 00", v); end
  endtask

  task automatic test_fifo_overflow();
    logic [34:0] e;
    logic [7:0]  v;
    int          n;
    ext_wr_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= WFIFO_DEPTH; i++) begin
      e = {3'd1, 24'($urandom), 8'($urandom)};
      mem_wr(e[34:32], e[31:8], e[7:0]);
      if (i < WFIFO_DEPTH) exp_q.push_back(e);
    end
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h80) begin n_fail++; $display("FAIL overflow_status: got %h want 80", v); end
    ext_wr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 4 * WFIFO_DEPTH && exp_q.size() != 0; c++) begin
      if (ext_wr_valid) begin
        n_checks++; if ({ext_wr_space, ext_wr_addr, ext_wr_data} !== exp_q[0]) begin
          n_fail++; $display("FAIL overflow_order%0d: got %h want %h", n, {ext_wr_space, ext_wr_addr, ext_wr_data}, exp_q[0]); end
        void'(exp_q.pop_front());
        n++;
      end
      step();
    end
    n_checks++; if (n != WFIFO_DEPTH || ext_wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL overflow_count: got %0d pops valid=%b want %0d pops valid=0", n, ext_wr_valid, WFIFO_DEPTH); end
    ext_wr_ready = 1'b0;
    wr_reg(7'd6, 8'h80);
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL overflow_clear: got %h want 00", v); end
  endtask

  task automatic test_drain_read();
    logic [34:0] e;
    logic [23:0] ra;
    int          pops;
    logic        seen;
    ext_wr_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      e = {3'd1, 24'($urandom), 8'($urandom)};
      mem_wr(e[34:32], e[31:8], e[7:0]);
      exp_q.push_back(e);
    end
    ra = 24'($urandom);
    mem_rd_req = 1'b1; mem_rd_space = 3'd1; mem_rd_addr = ra;
    step();
    mem_rd_req = 1'b0;
    repeat (3) begin
      n_checks++; if (ext_rd_req !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got ext_rd_req=%b want 0", ext_rd_req); end
      step();
    end
    ext_wr_ready = 1'b1;
    pops = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (ext_rd_req) begin
        seen = 1'b1;
        n_checks++; if (pops != 3) begin n_fail++; $display("FAIL drain_order: got %0d pops before req want 3", pops); end
        n_checks++; if (ext_rd_space !== 3'd1 || ext_rd_addr !== ra) begin
          n_fail++; $display("FAIL drain_rd_addr: got %h/%h want 1/%h", ext_rd_space, ext_rd_addr, ra); end
      end else begin
        if (ext_wr_valid) begin
          n_checks++; if (exp_q.size() == 0 || {ext_wr_space, ext_wr_addr, ext_wr_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL drain_pop%0d: got %h want %0d queued", pops, {ext_wr_space, ext_wr_addr, ext_wr_data}, exp_q.size()); end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pops++;
        end
        step();
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL drain_req_timeout: got no ext_rd_req want req within 40 cycles"); end
    ext_rd_ack = 1'b1; ext_rd_data = 8'h5C;
    step();
    ext_rd_ack = 1'b0;
    n_checks++; if (mem_rd_valid !== 1'b1 || mem_rd_data !== 8'h5C || ext_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL drain_ack: got valid=%b data=%h req=%b want 1/5c/0", mem_rd_valid, mem_rd_data, ext_rd_req); end
    step();
    n_checks++; if (mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_ack_pulse: got %b want 0", mem_rd_valid); end
    ext_wr_ready = 1'b0;
  endtask

  task automatic test_ext_read_random();
    logic [23:0] ra;
    logic [7:0]  d;
    int          w;
    for (int k = 0; k < 4; k++) begin
      ra = 24'($urandom); d = 8'($urandom);
      mem_rd_req = 1'b1; mem_rd_space = 3'd1; mem_rd_addr = ra;
      step();
      mem_rd_req = 1'b0;
      w = 0;
      while (!ext_rd_req && w < 10) begin step(); w++; end
      w = $urandom_range(0, 5);
      repeat (w) step();
      n_checks++; if (ext_rd_req !== 1'b1 || ext_rd_addr !== ra || mem_rd_valid !== 1'b0) begin
        n_fail++; $display("FAIL ext_read%0d_req: got req=%b addr=%h valid=%b want 1/%h/0", k, ext_rd_req, ext_rd_addr, mem_rd_valid, ra); end
      ext_rd_ack = 1'b1; ext_rd_data = d;
      step();
      ext_rd_ack = 1'b0;
      n_checks++; if (mem_rd_valid !== 1'b1 || mem_rd_data !== d) begin
        n_fail++; $display("FAIL ext_read%0d_data: got valid=%b data=%h want 1/%h", k, mem_rd_valid, mem_rd_data, d); end
      step();
    end
  endtask

  task automatic test_timeout();
    int         lat;
    logic       req_seen;
    logic [7:0] v;
    mem_rd_req = 1'b1; mem_rd_space = 3'd1; mem_rd_addr = 24'($urandom);
    step();
    mem_rd_req = 1'b0;
    lat = 1; req_seen = 1'b0;
    while (!mem_rd_valid && lat < RD_TIMEOUT + 20) begin
      if (ext_rd_req) req_seen = 1'b1;
      step();
      lat++;
    end
    n_checks++; if (mem_rd_valid !== 1'b1 || mem_rd_data !== 8'hFF) begin
      n_fail++; $display("FAIL timeout_resp: got valid=%b data=%h want 1/ff", mem_rd_valid, mem_rd_data); end
    n_checks++; if (lat < RD_TIMEOUT || lat > RD_TIMEOUT + 2) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", lat, RD_TIMEOUT, RD_TIMEOUT + 2); end
    n_checks++; if (!req_seen || ext_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_req: got seen=%b now=%b want 1/0", req_seen, ext_rd_req); end
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h40) begin n_fail++; $display("FAIL timeout_status: got %h want 40", v); end
    ext_rd_ack = 1'b1; ext_rd_data = 8'h33;
    step();
    ext_rd_ack = 1'b0;
    repeat (3) begin
      n_checks++; if (mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack: got valid=%b want 0", mem_rd_valid); end
      step();
    end
    wr_reg(7'd6, 8'h40);
  endtask

  task automatic test_irq();
    logic [7:0] v;
    wr_reg(7'd7, 8'h01);
    fabric_irq_set = 4'b0001;
    step();
    fabric_irq_set = 4'b0000;
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h01 || esp_irq !== 1'b0) begin n_fail++; $display("FAIL irq_set: got status=%h irq=%b want 01/0", v, esp_irq); end
    step();
    n_checks++; if (esp_irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b want 1", esp_irq); end
    reg_wr_req = 1'b1; reg_idx = 7'd6; reg_wdata = 8'h01; fabric_irq_set = 4'b0001;
    step();
    reg_wr_req = 1'b0; fabric_irq_set = 4'b0000;
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL irq_set_wins: got %h want 01", v); end
    fabric_irq_set = 4'b0100;
    step();
    fabric_irq_set = 4'b0000;
    wr_reg(7'd6, 8'h01);
    rd_reg(7'd6, v);
    n_checks++; if (v !== 8'h04 || esp_irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear: got status=%h irq=%b want 04/1", v, esp_irq); end
    step();
    n_checks++; if (esp_irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", esp_irq); end
    wr_reg(7'd7, 8'h04);
    n_checks++; if (esp_irq !== 1'b0) begin n_fail++; $display("FAIL irq_en_latency: got %b want 0", esp_irq); end
    step();
    n_checks++; if (esp_irq !== 1'b1) begin n_fail++; $display("FAIL irq_en_assert: got %b want 1", esp_irq); end
    wr_reg(7'd6, 8'h04);
    wr_reg(7'd7, 8'h00);
    step();
    n_checks++; if (esp_irq !== 1'b0) begin n_fail++; $display("FAIL irq_final: got %b want 0", esp_irq); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] e;
    logic        rdy;
    logic        psh;
    logic        pop;
    logic        ovf;
    logic [7:0]  v;
    int          sz;
    exp_q.delete();
    ovf = 1'b0;
    for (int c = 0; c < 200; c++) begin
      n_checks++; if (ext_wr_valid !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", c, ext_wr_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_checks++; if ({ext_wr_space, ext_wr_addr, ext_wr_data} !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_head c%0d: got %h want %h", c, {ext_wr_space, ext_wr_addr, ext_wr_data}, exp_q[0]); end
      end
      rdy = 1'($urandom_range(0, 1));
      psh = ($urandom_range(0, 3) != 0);
      e = {3'd1, 24'($urandom), 8'($urandom)};
      ext_wr_ready = rdy; mem_wr_en = psh; mem_space = e[34:32]; mem_wr_addr = e[31:8]; mem_wr_data = e[7:0];
      sz = exp_q.size();
      pop = (sz != 0) && rdy;
      step();
      if (pop) void'(exp_q.pop_front());
      if (psh) begin
        if (sz < WFIFO_DEPTH || pop) exp_q.push_back(e);
        else ovf = 1'b1;
      end
    end
    mem_wr_en = 1'b0; ext_wr_ready = 1'b1;
    for (int c = 0; c < 4 * WFIFO_DEPTH && exp_q.size() != 0; c++) begin
      n_checks++; if (ext_wr_valid !== 1'b1 || {ext_wr_space, ext_wr_addr, ext_wr_data} !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_drain: got valid=%b %h want %h", ext_wr_valid, {ext_wr_space, ext_wr_addr, ext_wr_data}, exp_q[0]); end
      void'(exp_q.pop_front());
      step();
    end
    n_checks++; if (ext_wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got valid=%b want 0", ext_wr_valid); end
    rd_reg(7'd6, v);
    n_checks++; if (v !== (ovf ? 8'h80 : 8'h00)) begin n_fail++; $display("FAIL b2b_ovf_status: got %h want %h", v, ovf ? 8'h80 : 8'h00); end
    wr_reg(7'd6, 8'h80);
    ext_wr_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    ext_wr_ready = 1'b0;
    mem_wr(3'd1, 24'($urandom), 8'($urandom));
    mem_wr(3'd1, 24'($urandom), 8'($urandom));
    mem_rd_req = 1'b1; mem_rd_space = 3'd1; mem_rd_addr = 24'($urandom);
    step();
    mem_rd_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (ext_wr_valid !== 1'b0 || ext_rd_req !== 1'b0 || mem_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got wr_valid=%b rd_req=%b valid=%b want 0/0/0", ext_wr_valid, ext_rd_req, mem_rd_valid); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_USER; i++) ref_user[i] = 8'h00;
    ext_rd_ack = 1'b1; ext_rd_data = 8'h77;
    step();
    ext_rd_ack = 1'b0;
    repeat (4) begin
      n_checks++; if (mem_rd_valid !== 1'b0 || ext_rd_req !== 1'b0) begin
        n_fail++; $display("FAIL abort_response: got valid=%b req=%b want 0/0", mem_rd_valid, ext_rd_req); end
      step();
    end
    n_checks++; if (host_regs !== exp_host()) begin n_fail++; $display("FAIL abort_host_regs: got %h want %h", host_regs, exp_host()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_id_regs();
    test_user_regs();
    test_local_mem();
    test_fifo_overflow();
    test_drain_read();
    test_ext_read_random();
    test_timeout();
    test_irq();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
